// File: rtl/axis_adc_avg_packetizer.sv
// axis_adc_avg_packetizer
// Boxcar-averages groups of 2^LOG2_AVG raw ADC samples, frames the averages
// into PKT_LEN-word packets with tlast, and buffers them in a first-word-fall-
// through FIFO so the DMA side can stall without disturbing the ADC side.
// Averages that arrive while the FIFO is full are dropped and counted.
module axis_adc_avg_packetizer #(
    parameter int LOG2_AVG   = 2,
    parameter int PKT_LEN    = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        clear_stats,
    input  logic [15:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] drop_count,
    output logic        overflow
);

    localparam int ACCW = 16 + LOG2_AVG;
    localparam int SCW  = (LOG2_AVG == 0) ? 1 : LOG2_AVG;
    localparam int WCW  = (PKT_LEN <= 1) ? 1 : $clog2(PKT_LEN);
    localparam int AW   = $clog2(FIFO_DEPTH);

    localparam logic [SCW-1:0] SCNT_MAX  = SCW'((1 << LOG2_AVG) - 1);
    localparam logic [WCW-1:0] WCNT_MAX  = WCW'(PKT_LEN - 1);
    localparam logic [AW:0]    FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP_PENDING
    } state_t;

    state_t          state_q;
    logic            sReady_q;
    logic [ACCW-1:0] acc_q;
    logic [SCW-1:0]  sampleCnt_q;
    logic [WCW-1:0]  wordCnt_q;
    logic [15:0]     dropCount_q;
    logic            overflow_q;

    logic [16:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr_q;
    logic [AW-1:0]   rdPtr_q;
    logic [AW:0]     fifoCount_q;

    logic            beatAcc;
    logic            groupDone;
    logic [ACCW-1:0] sum_d;
    logic [15:0]     avg_d;
    logic            tlast_d;
    logic            pushOk;
    logic            pushFail;
    logic            pop;
    logic            fifoValid;

    // Datapath helpers: running sum, truncated average and push/pop qualifiers.
    // Occupancy for the push decision is the registered count, so a pop in the
    // same cycle never makes room for that cycle's push.
    always_comb begin
        beatAcc   = s_axis_tvalid && sReady_q && (state_q != IDLE);
        groupDone = beatAcc && (sampleCnt_q == SCNT_MAX);
        sum_d     = acc_q + ACCW'(s_axis_tdata);
        avg_d     = 16'(sum_d >> LOG2_AVG);
        tlast_d   = (wordCnt_q == WCNT_MAX);
        pushOk    = groupDone && (fifoCount_q < FIFO_FULL);
        pushFail  = groupDone && !(fifoCount_q < FIFO_FULL);
        fifoValid = (fifoCount_q != '0);
        pop       = fifoValid && m_axis_tready;
    end

    // Control FSM together with accumulator, packet word counter and drop stats.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            sReady_q    <= 1'b0;
            acc_q       <= '0;
            sampleCnt_q <= '0;
            wordCnt_q   <= '0;
            dropCount_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sReady_q <= 1'b1;

            if (clear_stats) begin
                dropCount_q <= '0;
                overflow_q  <= 1'b0;
            end else if (pushFail) begin
                if (dropCount_q != 16'hFFFF) begin
                    dropCount_q <= dropCount_q + 16'd1;
                end
                overflow_q <= 1'b1;
            end

            if (state_q == IDLE) begin
                acc_q       <= '0;
                sampleCnt_q <= '0;
                wordCnt_q   <= '0;
            end else if (beatAcc) begin
                if (groupDone) begin
                    acc_q       <= '0;
                    sampleCnt_q <= '0;
                end else begin
                    acc_q       <= sum_d;
                    sampleCnt_q <= sampleCnt_q + SCW'(1);
                end
            end

            if (pushOk) begin
                wordCnt_q <= tlast_d ? '0 : wordCnt_q + WCW'(1);
            end

            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        state_q <= STOP_PENDING;
                    end
                end
                STOP_PENDING: begin
                    if (enable) begin
                        state_q <= RUN;
                    end else if (pushOk && tlast_d) begin
                        state_q <= IDLE;
                    end else if ((wordCnt_q == '0) && !pushOk) begin
                        state_q     <= IDLE;
                        acc_q       <= '0;
                        sampleCnt_q <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // FIFO storage; tdata and tlast travel together. Not reset because the
    // pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= {tlast_d, avg_d};
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count alone.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            fifoCount_q <= '0;
        end else begin
            if (pushOk) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({pushOk, pop})
                2'b10:   fifoCount_q <= fifoCount_q + (AW + 1)'(1);
                2'b01:   fifoCount_q <= fifoCount_q - (AW + 1)'(1);
                default: fifoCount_q <= fifoCount_q;
            endcase
        end
    end

    assign s_axis_tready = sReady_q;
    assign m_axis_tvalid = fifoValid;
    assign m_axis_tdata  = fifoValid ? mem_q[rdPtr_q][15:0] : 16'h0000;
    assign m_axis_tlast  = fifoValid ? mem_q[rdPtr_q][16] : 1'b0;
    assign drop_count    = dropCount_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_axis_adc_avg_packetizer.sv
// tb_axis_adc_avg_packetizer
// Directed scenarios for the averaging packetizer with LOG2_AVG=2, PKT_LEN=4
// and FIFO_DEPTH=16. Output beats are logged into a queue at the moment they
// are handed off, and each scenario compares that log against hand-computed
// words of the form {tlast, tdata}.
module tb_axis_adc_avg_packetizer;

    localparam int LOG2_AVG   = 2;
    localparam int PKT_LEN    = 4;
    localparam int FIFO_DEPTH = 16;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        clear_stats = 1'b0;
    logic [15:0] s_axis_tdata = 16'h0000;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic [15:0] drop_count;
    logic        overflow;

    int checkCount = 0;
    int passCount  = 0;
    logic [16:0] outQ[$];

    axis_adc_avg_packetizer #(
        .LOG2_AVG  (LOG2_AVG),
        .PKT_LEN   (PKT_LEN),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .enable       (enable),
        .clear_stats  (clear_stats),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .drop_count   (drop_count),
        .overflow     (overflow)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // One clock: log the beat the coming edge will hand off, then settle 1ns past it.
    task automatic tick();
        if (m_axis_tvalid && m_axis_tready) begin
            outQ.push_back({m_axis_tlast, m_axis_tdata});
        end
        @(posedge clk);
        #1;
    endtask

    // Present one input sample for exactly one edge.
    task automatic applyStimulus(input logic [15:0] v);
        s_axis_tdata  = v;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
    endtask

    // Four identical samples form a group whose average is the sample itself.
    task automatic sendGroup(input logic [15:0] v);
        repeat (4) applyStimulus(v);
    endtask

    task automatic idleCycles(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idleCycles(3);
        checkCount++;
        if (s_axis_tready !== 1'b0) $display("[TB] FAIL reset_s_tready: got %b expected 0", s_axis_tready);
        else passCount++;
        checkCount++;
        if (m_axis_tvalid !== 1'b0) $display("[TB] FAIL reset_m_tvalid: got %b expected 0", m_axis_tvalid);
        else passCount++;
        checkCount++;
        if (m_axis_tdata !== 16'h0000) $display("[TB] FAIL reset_m_tdata: got %h expected 0000", m_axis_tdata);
        else passCount++;
        checkCount++;
        if (m_axis_tlast !== 1'b0) $display("[TB] FAIL reset_m_tlast: got %b expected 0", m_axis_tlast);
        else passCount++;
        checkCount++;
        if (drop_count !== 16'h0000) $display("[TB] FAIL reset_drop_count: got %h expected 0000", drop_count);
        else passCount++;
        checkCount++;
        if (overflow !== 1'b0) $display("[TB] FAIL reset_overflow: got %b expected 0", overflow);
        else passCount++;
        resetn = 1'b1;
        tick();
        checkCount++;
        if (s_axis_tready !== 1'b1) $display("[TB] FAIL release_s_tready: got %b expected 1", s_axis_tready);
        else passCount++;
    endtask

    task automatic test_basic_average();
        enable        = 1'b1;
        m_axis_tready = 1'b1;
        tick();
        outQ.delete();
        for (int g = 0; g < 16; g++) begin
            applyStimulus(16'd4);
            applyStimulus(16'd8);
            applyStimulus(16'd12);
            applyStimulus(16'd16);
        end
        idleCycles(4);
        checkCount++;
        if (outQ.size() !== 16) $display("[TB] FAIL basic_count: got %0d expected 16", outQ.size());
        else passCount++;
        for (int i = 0; i < 16; i++) begin
            logic [16:0] expWord;
            expWord = {(i % 4) == 3, 16'h000A};
            checkCount++;
            if (outQ[i] !== expWord) $display("[TB] FAIL basic_word%0d: got %h expected %h", i, outQ[i], expWord);
            else passCount++;
        end
    endtask

    task automatic test_truncation();
        logic [16:0] expWords[4];
        expWords = '{{1'b0, 16'h0001}, {1'b0, 16'hFFFF}, {1'b0, 16'h0000}, {1'b1, 16'h0002}};
        outQ.delete();
        applyStimulus(16'd1);
        applyStimulus(16'd1);
        applyStimulus(16'd1);
        applyStimulus(16'd2);
        checkCount++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0001)
            $display("[TB] FAIL latency_first_word: got valid=%b data=%h expected valid=1 data=0001", m_axis_tvalid, m_axis_tdata);
        else passCount++;
        sendGroup(16'hFFFF);
        applyStimulus(16'd0);
        applyStimulus(16'd0);
        applyStimulus(16'd0);
        applyStimulus(16'd3);
        sendGroup(16'd2);
        idleCycles(4);
        checkCount++;
        if (outQ.size() !== 4) $display("[TB] FAIL trunc_count: got %0d expected 4", outQ.size());
        else passCount++;
        for (int i = 0; i < 4; i++) begin
            checkCount++;
            if (outQ[i] !== expWords[i]) $display("[TB] FAIL trunc_word%0d: got %h expected %h", i, outQ[i], expWords[i]);
            else passCount++;
        end
    endtask

    task automatic test_backpressure();
        m_axis_tready = 1'b0;
        outQ.delete();
        for (int g = 1; g <= 17; g++) sendGroup(16'(g));
        idleCycles(2);
        checkCount++;
        if (drop_count !== 16'd1) $display("[TB] FAIL bp_drop_count: got %0d expected 1", drop_count);
        else passCount++;
        checkCount++;
        if (overflow !== 1'b1) $display("[TB] FAIL bp_overflow: got %b expected 1", overflow);
        else passCount++;
        checkCount++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'd1 || m_axis_tlast !== 1'b0)
            $display("[TB] FAIL bp_head_stable: got valid=%b data=%h last=%b expected 1/0001/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast);
        else passCount++;
        m_axis_tready = 1'b1;
        idleCycles(20);
        checkCount++;
        if (outQ.size() !== 16) $display("[TB] FAIL bp_drain_count: got %0d expected 16", outQ.size());
        else passCount++;
        for (int i = 0; i < 16; i++) begin
            logic [16:0] expWord;
            expWord = {(i % 4) == 3, 16'(i + 1)};
            checkCount++;
            if (outQ[i] !== expWord) $display("[TB] FAIL bp_word%0d: got %h expected %h", i, outQ[i], expWord);
            else passCount++;
        end
        for (int g = 100; g < 104; g++) sendGroup(16'(g));
        idleCycles(4);
        checkCount++;
        if (outQ.size() !== 20) $display("[TB] FAIL bp_next_count: got %0d expected 20", outQ.size());
        else passCount++;
        for (int i = 0; i < 4; i++) begin
            logic [16:0] expWord;
            expWord = {i == 3, 16'(100 + i)};
            checkCount++;
            if (outQ[16 + i] !== expWord) $display("[TB] FAIL bp_next_word%0d: got %h expected %h", i, outQ[16 + i], expWord);
            else passCount++;
        end
    endtask

    task automatic test_clear_collision();
        clear_stats = 1'b1;
        tick();
        clear_stats = 1'b0;
        checkCount++;
        if (drop_count !== 16'd0 || overflow !== 1'b0)
            $display("[TB] FAIL clear_pulse: got drop=%0d ovf=%b expected 0/0", drop_count, overflow);
        else passCount++;
        m_axis_tready = 1'b0;
        for (int g = 0; g < 16; g++) sendGroup(16'd1);
        for (int g = 0; g < 5; g++) sendGroup(16'd2);
        checkCount++;
        if (drop_count !== 16'd5 || overflow !== 1'b1)
            $display("[TB] FAIL five_drops: got drop=%0d ovf=%b expected 5/1", drop_count, overflow);
        else passCount++;
        applyStimulus(16'd3);
        applyStimulus(16'd3);
        applyStimulus(16'd3);
        clear_stats = 1'b1;
        applyStimulus(16'd3);
        clear_stats = 1'b0;
        checkCount++;
        if (drop_count !== 16'd0) $display("[TB] FAIL collision_drop_count: got %0d expected 0", drop_count);
        else passCount++;
        checkCount++;
        if (overflow !== 1'b0) $display("[TB] FAIL collision_overflow: got %b expected 0", overflow);
        else passCount++;
        m_axis_tready = 1'b1;
        idleCycles(20);
        outQ.delete();
    endtask

    task automatic test_enable_drop();
        outQ.delete();
        sendGroup(16'd21);
        sendGroup(16'd22);
        enable = 1'b0;
        sendGroup(16'd23);
        sendGroup(16'd24);
        sendGroup(16'd25);
        sendGroup(16'd26);
        idleCycles(4);
        checkCount++;
        if (outQ.size() !== 4) $display("[TB] FAIL stop_count: got %0d expected 4", outQ.size());
        else passCount++;
        for (int i = 0; i < 4; i++) begin
            logic [16:0] expWord;
            expWord = {i == 3, 16'(21 + i)};
            checkCount++;
            if (outQ[i] !== expWord) $display("[TB] FAIL stop_word%0d: got %h expected %h", i, outQ[i], expWord);
            else passCount++;
        end
        checkCount++;
        if (m_axis_tvalid !== 1'b0) $display("[TB] FAIL stop_idle_valid: got %b expected 0", m_axis_tvalid);
        else passCount++;
        enable = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        logic [16:0] expWords[4];
        expWords = '{{1'b0, 16'd41}, {1'b0, 16'd50}, {1'b0, 16'd60}, {1'b1, 16'd70}};
        m_axis_tready = 1'b0;
        sendGroup(16'd5);
        sendGroup(16'd6);
        sendGroup(16'd7);
        applyStimulus(16'd9);
        applyStimulus(16'd9);
        resetn = 1'b0;
        tick();
        checkCount++;
        if (m_axis_tvalid !== 1'b0) $display("[TB] FAIL midreset_m_tvalid: got %b expected 0", m_axis_tvalid);
        else passCount++;
        checkCount++;
        if (s_axis_tready !== 1'b0) $display("[TB] FAIL midreset_s_tready: got %b expected 0", s_axis_tready);
        else passCount++;
        checkCount++;
        if (drop_count !== 16'd0) $display("[TB] FAIL midreset_drop_count: got %0d expected 0", drop_count);
        else passCount++;
        resetn = 1'b1;
        tick();
        m_axis_tready = 1'b1;
        outQ.delete();
        applyStimulus(16'd40);
        applyStimulus(16'd40);
        applyStimulus(16'd40);
        applyStimulus(16'd44);
        sendGroup(16'd50);
        sendGroup(16'd60);
        sendGroup(16'd70);
        idleCycles(4);
        checkCount++;
        if (outQ.size() !== 4) $display("[TB] FAIL midreset_count: got %0d expected 4", outQ.size());
        else passCount++;
        for (int i = 0; i < 4; i++) begin
            checkCount++;
            if (outQ[i] !== expWords[i]) $display("[TB] FAIL midreset_word%0d: got %h expected %h", i, outQ[i], expWords[i]);
            else passCount++;
        end
    endtask

    // Scenario sequence; each one leaves the DUT enabled with an empty FIFO.
    initial begin
        test_reset();
        test_basic_average();
        test_truncation();
        test_backpressure();
        test_clear_collision();
        test_enable_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/axis_adc_avg_packetizer.md
# axis_adc_avg_packetizer

Downstream stage of the MAX1119x AXIS ADC reader. It accepts 16-bit raw samples over AXI-Stream and boxcar-averages each group of 2^LOG2_AVG samples into one word. It frames the averages into fixed-length packets with tlast, ready for the DMA stream. An internal FWFT FIFO absorbs DMA backpressure, and a saturating counter reports dropped averages.

## Interface
- LOG2_AVG, 2, log2 of samples per average; legal range 0..8.
- PKT_LEN, 64, averaged words per packet; must be ≥1.
- FIFO_DEPTH, 16, output FIFO entries; power of two, ≥2.
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- enable  in  1  run request.
- clear_stats  in  1  one-cycle pulse; clears drop_count and overflow.
- s_axis_tdata  in  16  raw ADC sample.
- s_axis_tvalid  in  1  sample valid.
- s_axis_tready  out  1  sample accept.
- m_axis_tdata  out  16  averaged sample.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tlast  out  1  last word of packet.
- drop_count  out  16  averages lost to a full FIFO; saturates at 0xFFFF.
- overflow  out  1  sticky; set on any drop.

## Operation
- s_axis_tready is a registered output. It is 0 during reset and 1 from the first cycle after resetn is released. The block never backpressures upstream.
- An input beat is accepted when s_axis_tvalid && s_axis_tready.
- State machine has three states: IDLE, RUN, STOP_PENDING.
  - IDLE: accepted beats are discarded. Accumulator, sample count and word count are held at 0. Goes to RUN when enable=1.
  - RUN: beats are accumulated. Goes to STOP_PENDING when enable=0.
  - STOP_PENDING: accumulation continues. Goes back to RUN if enable=1. Goes to IDLE on the cycle the push of the packet's tlast word succeeds. If word count is already 0 on entry, goes to IDLE immediately.
- Accumulator is 16+LOG2_AVG bits wide. The sample counter counts 0..2^LOG2_AVG-1.
- On an accepted beat with sample count = 2^LOG2_AVG-1:
  - avg = (acc + sample) >> LOG2_AVG, truncated with no rounding.
  - acc and the sample counter are cleared.
  - A push is attempted with tlast = (word count == PKT_LEN-1).
- When LOG2_AVG=0, every sample passes through unchanged.
- Push outcome:
  - Succeeds if FIFO occupancy < FIFO_DEPTH. Occupancy is the registered count at the start of the cycle. A pop in the same cycle does not free a slot for that cycle's push.
  - On success, word count increments and wraps to 0 after PKT_LEN-1.
  - On failure, the average is discarded and word count does not advance. Every emitted packet therefore has exactly PKT_LEN words.
  - On failure, drop_count increments (saturating) and overflow is set.
- clear_stats takes priority over a coincident drop: drop_count becomes 0 and overflow becomes 0.
- FIFO is first-word-fall-through, with m_axis_tvalid = !empty. tdata and tlast are stored together.
  - A pop occurs on m_axis_tvalid && m_axis_tready.
  - Simultaneous push and pop with occupancy between 1 and FIFO_DEPTH-1 leaves occupancy unchanged.
  - Data order is strictly preserved.

## Timing
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, drop_count=0, overflow=0. State resets to IDLE, the FIFO is emptied and all counters are cleared.
- Reset in the middle of operation discards any partial average, partial packet and FIFO contents in the same cycle.
- Latency: the final sample of a group is accepted at edge t. When the FIFO was empty, the average is pushed at edge t and m_axis_tvalid=1 with valid data in the cycle after edge t (1-cycle latency).
- m_axis_tdata and m_axis_tlast are stable while m_axis_tvalid=1 && m_axis_tready=0.
- Throughput: one input beat per cycle and one output beat per cycle.
- RUN→STOP_PENDING and STOP_PENDING→IDLE each take effect on the clock edge that observes the condition.

## Test plan
- Basic averaging (LOG2_AVG=2, PKT_LEN=4, m_axis_tready=1): input 4,8,12,16 repeated 16 times. Required: 16 outputs of 10 (0x000A), tlast on outputs 4, 8, 12 and 16.
- Truncation and full scale: input 1,1,1,2 must give 1. Input 0xFFFF ×4 must give 0xFFFF with no wrap.
- Backpressure (FIFO_DEPTH=16): hold m_axis_tready=0 and produce 17 averages.
  - Required: occupancy 16, drop_count=1, overflow=1.
  - Then raise m_axis_tready. Required: 16 words in order, tlast on every 4th, and the next produced average starts a word count of 0 (no tlast misalignment).
- Enable drop mid-packet: deassert enable after 2 words of a packet. Required: exactly 2 more words, the last with tlast=1, then IDLE. Further input produces no output.
- Reset mid-operation: 3 words in the FIFO and 2 samples accumulated, pulse resetn=0 for one cycle.
  - Required in the next cycle: m_axis_tvalid=0, s_axis_tready=0, drop_count=0.
  - After release, the first output is the average of 4 new samples, with word count starting at 0.
- Stats clear collision: clear_stats is asserted in the same cycle as a failed push with drop_count=5. Required: drop_count=0 and overflow=0 on the next cycle.
